pio_loader: RTL

- Sequencer directly upstream of the pio block; drives its din/index/action/mindex bus.
- After reset it streams a program ROM into PIO instruction memory, then replays a configuration ROM of (mindex, action, data) entries.
- It then enters run mode, forwarding user push requests into a selected state machine's TX FIFO under a valid/ready handshake gated by the PIO full flags.
- This replaces the ad-hoc loader state machine in each top-level.

---
 rtl/pio_pkg.sv | 35 +++
 rtl/pio_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO loader: action codes, config entry layout, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pio_pkg;

  // Action codes understood by the pio block.
  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_PULL  = 4'd5;

  // Config ROM entry layout: [37:36] mindex, [35:32] action, [31:0] data.
  localparam int CONF_W         = 38;
  localparam int CONF_MINDEX_HI = 37;
  localparam int CONF_MINDEX_LO = 36;
  localparam int CONF_ACTION_HI = 35;
  localparam int CONF_ACTION_LO = 32;
  localparam int CONF_DATA_HI   = 31;
  localparam int CONF_DATA_LO   = 0;

  // Packed view of one config entry; field order matches the offsets above.
  typedef struct packed {
    logic [1:0]  mindex;
    logic [3:0]  action;
    logic [31:0] data;
  } conf_entry_t;

  // Loader sequence: program load, config replay, then run mode.
  typedef enum logic [1:0] {
    PROG = 2'd0,
    CONF = 2'd1,
    RUN  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pio_loader.sv
// Sequencer in front of the pio block: loads instruction memory, replays config, then forwards pushes.
// Latency: ROM words reach the pio bus 2 cycles after their address; accepted push/pull drives the bus 1 cycle later.
// Backpressure: push_ready drops while the target TX FIFO is full and for one cooldown cycle after each accept.
//
// Optional feature: define PIO_LOADER_PULL_EN to add the RX pull handshake
// (pull_req, pull_mindex, pull_ready, pull_valid, pull_data).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   prog_addr / prog_data      program ROM read port (sync ROM, 1-cycle latency)
//   conf_addr / conf_data      config ROM read port (sync ROM, 1-cycle latency)
//   pio_din/index/action/mindex registered command bus into the pio block
//   full, empty, pio_dout      status and read data from the pio block
//   push_valid/ready/data/mindex user push handshake (run mode only)
//   loaded                     high from entry into run mode until reset
module pio_loader
  import pio_pkg::*;
#(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 11
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  conf_addr,
  input  logic [37:0] conf_data,
  output logic [31:0] pio_din,
  output logic [4:0]  pio_index,
  output logic [3:0]  pio_action,
  output logic [1:0]  pio_mindex,
  input  logic [3:0]  full,
  input  logic [3:0]  empty,
  input  logic [31:0] pio_dout,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_data,
  input  logic [1:0]  push_mindex,
  output logic        loaded
`ifdef PIO_LOADER_PULL_EN
  ,
  input  logic        pull_req,
  input  logic [1:0]  pull_mindex,
  output logic        pull_ready,
  output logic        pull_valid,
  output logic [31:0] pull_data
`endif
);

  localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
  localparam logic [4:0] CONF_LAST = 5'(CONF_LEN - 1);

  loader_state_t state;

  // ROM read tracking: the address issued this cycle returns data next cycle,
  // so these flags mark which ROM (if any) holds a word to forward now.
  logic        pend_prog;
  logic [4:0]  pend_idx;
  logic        pend_conf;
  logic        pend_conf_last;
  logic        conf_issued;   // all config addresses issued, waiting for drain
  logic        last_wr;       // final config write is on the bus this cycle

  logic        cooldown;      // one dead cycle after any accepted transfer
  logic        run;
  logic        push_acc;
  logic        accept;

  conf_entry_t conf_entry;

  assign conf_entry = conf_data;
  assign run        = (state == RUN);

  // Ready depends only on state and the pio flags, never on push_valid.
  assign push_ready = run & ~full[push_mindex] & ~cooldown;
  assign push_acc   = push_valid & push_ready;

`ifdef PIO_LOADER_PULL_EN
  logic pull_acc;
  logic pull_pend;          // pull action is on the bus; pio_dout valid at its end

  // Push wins a same-cycle contest, so pull yields to an accepted push.
  assign pull_ready = run & ~empty[pull_mindex] & ~cooldown & ~push_acc;
  assign pull_acc   = pull_req & pull_ready;
  assign accept     = push_acc | pull_acc;
`else
  logic unused_pull_inputs;
  assign unused_pull_inputs = ^{empty, pio_dout};
  assign accept             = push_acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PROG;
      prog_addr      <= '0;
      conf_addr      <= '0;
      pio_din        <= '0;
      pio_index      <= '0;
      pio_action     <= ACT_NONE;
      pio_mindex     <= '0;
      loaded         <= 1'b0;
      pend_prog      <= 1'b0;
      pend_idx       <= '0;
      pend_conf      <= 1'b0;
      pend_conf_last <= 1'b0;
      conf_issued    <= 1'b0;
      last_wr        <= 1'b0;
      cooldown       <= 1'b0;
`ifdef PIO_LOADER_PULL_EN
      pull_pend      <= 1'b0;
      pull_valid     <= 1'b0;
      pull_data      <= '0;
`endif
    end else begin
      // Every bus command is a single-cycle pulse.
      pio_action <= ACT_NONE;
      pio_din    <= '0;
      pio_index  <= '0;
      pio_mindex <= '0;
      pend_prog  <= 1'b0;
      pend_conf  <= 1'b0;
      last_wr    <= 1'b0;
      cooldown   <= 1'b0;
`ifdef PIO_LOADER_PULL_EN
      pull_pend  <= 1'b0;
      pull_valid <= 1'b0;
`endif

      case (state)
        PROG: begin
          pend_prog <= 1'b1;
          pend_idx  <= prog_addr;
          if (prog_addr == PROG_LAST) begin
            state <= CONF;
          end else begin
            prog_addr <= prog_addr + 5'd1;
          end
        end

        CONF: begin
          if (!conf_issued) begin
            pend_conf      <= 1'b1;
            pend_conf_last <= (conf_addr == CONF_LAST);
            if (conf_addr == CONF_LAST) begin
              conf_issued <= 1'b1;
            end else begin
              conf_addr <= conf_addr + 5'd1;
            end
          end
          // Leave only once the last entry has actually been driven.
          if (last_wr) begin
            state  <= RUN;
            loaded <= 1'b1;
          end
        end

        RUN: begin
          cooldown <= accept;
          if (push_acc) begin
            pio_action <= ACT_PUSH;
            pio_din    <= push_data;
            pio_mindex <= push_mindex;
          end
`ifdef PIO_LOADER_PULL_EN
          else if (pull_acc) begin
            pio_action <= ACT_PULL;
            pio_mindex <= pull_mindex;
          end
          pull_pend <= pull_acc;
`endif
        end

        default: state <= PROG;
      endcase

      // Forward ROM words that arrived this cycle. The last program word
      // lands after the state has already moved to CONF.
      if (pend_prog) begin
        pio_action <= ACT_INSTR;
        pio_din    <= {16'b0, prog_data};
        pio_index  <= pend_idx;
        pio_mindex <= 2'd0;
      end

      // Config entries go out verbatim; an action of 0 is simply an idle slot.
      if (pend_conf) begin
        pio_action <= conf_entry.action;
        pio_din    <= conf_entry.data;
        pio_index  <= 5'd0;
        pio_mindex <= conf_entry.mindex;
        last_wr    <= pend_conf_last;
      end

`ifdef PIO_LOADER_PULL_EN
      // pio_dout answers the pull action during the cycle it is on the bus.
      if (pull_pend) begin
        pull_valid <= 1'b1;
        pull_data  <= pio_dout;
      end
`endif
    end
  end

endmodule
